// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: definitions shared by the TDM receive path and the
// matching mux-side serializer.
//   TDM_DEF_NCH   - default channels per frame
//   TDM_DEF_WIDTH - default bits per sample
//   tdm_state_t   - alignment FSM state (HUNT = unaligned, RUN = aligned)
package tdm_demux_pkg;

  localparam int TDM_DEF_NCH   = 4;
  localparam int TDM_DEF_WIDTH = 1;

  typedef enum logic {
    TDM_HUNT = 1'b0,
    TDM_RUN  = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: modulo-NCH slot counter.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset (slot -> 0)
//   en    - advance slot by one (wraps NCH-1 -> 0)
//   load1 - force slot to 1 (start of frame); has priority over en
//   slot  - current slot index
//   wrap  - en while slot == NCH-1 (frame completes on this edge)
module tdm_slot_ctr
  import tdm_demux_pkg::*;
#(
  parameter  int NCH = TDM_DEF_NCH,
  localparam int SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load1,
  output logic [SW-1:0] slot,
  output logic          wrap
);

  logic at_last;

  assign at_last = (slot == SW'(NCH - 1));
  assign wrap    = en && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (en) begin
      slot <= at_last ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer with frame-marker alignment.
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   din        - sample for the current slot
//   din_valid  - din/frame_i qualified; low stalls everything
//   frame_i    - din is slot 0 of a frame
//   dout       - last complete frame, channel k at dout[k*WIDTH +: WIDTH]
//   dout_valid - one-cycle pulse when dout updates
//   slot       - slot the next valid sample will be written to
//   locked     - high while aligned (RUN)
//   sync_err   - one-cycle pulse on early or missing frame marker
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter  int WIDTH = TDM_DEF_WIDTH,
  parameter  int NCH   = TDM_DEF_NCH,
  localparam int SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_i,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic [SW-1:0]        slot,
  output logic                 locked,
  output logic                 sync_err
);

  tdm_state_t state, state_nxt;

  logic             shadow_we;
  logic [SW-1:0]    shadow_idx;
  logic             ctr_en;
  logic             ctr_load1;
  logic             err_nxt;
  logic             frame_done;

  // The last slot goes straight from din into dout, so only NCH-1 shadows.
  logic [WIDTH-1:0] shadow [NCH-1];

  tdm_slot_ctr #(.NCH(NCH)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .slot  (slot),
    .wrap  (frame_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= TDM_HUNT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      unique case (state)
        TDM_HUNT: if (frame_i) state_nxt = TDM_RUN;
        TDM_RUN:  if (!frame_i && slot == '0) state_nxt = TDM_HUNT;
        default:  state_nxt = TDM_HUNT;
      endcase
    end
  end

  // Datapath control decode
  always_comb begin
    shadow_we  = 1'b0;
    shadow_idx = slot;
    ctr_en     = 1'b0;
    ctr_load1  = 1'b0;
    err_nxt    = 1'b0;
    if (din_valid) begin
      unique case (state)
        TDM_HUNT: begin
          if (frame_i) begin
            shadow_we  = 1'b1;
            shadow_idx = '0;
            ctr_load1  = 1'b1;
          end
        end
        TDM_RUN: begin
          if (frame_i) begin
            // Marker always restarts the frame; it is an error unless on slot 0.
            shadow_we  = 1'b1;
            shadow_idx = '0;
            ctr_load1  = 1'b1;
            err_nxt    = (slot != '0);
          end else if (slot != '0) begin
            shadow_we  = 1'b1;
            ctr_en     = 1'b1;
          end else begin
            err_nxt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign locked = (state == TDM_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH - 1; k++) shadow[k] <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (shadow_we && shadow_idx != SW'(NCH - 1)) shadow[shadow_idx] <= din;
      if (frame_done) begin
        for (int unsigned k = 0; k < NCH - 1; k++) dout[k*WIDTH +: WIDTH] <= shadow[k];
        dout[(NCH-1)*WIDTH +: WIDTH] <= din;
      end
      dout_valid <= frame_done;
      sync_err   <= err_nxt;
    end
  end

endmodule
